// File: rtl/vendor_pkg.sv
// Shared definitions for the vending output side: channel state encoding,
// default actuator timing and a small sizing helper.
package vendor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_FAULT = 3'd4
  } chan_state_t;

  typedef enum logic {
    CH_PROD = 1'b0,
    CH_COIN = 1'b1
  } chan_id_t;

  localparam int DEF_PULSE_CYC = 8;
  localparam int DEF_TMO_CYC   = 16;
  localparam int DEF_GAP_CYC   = 4;
  localparam int DEF_CNT_W     = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vendor_eject_channel.sv
// One actuator channel: pending-job counter, drive/wait/gap/fault FSM and
// a shared down-counter timer that is reloaded on every state entry.
module vendor_eject_channel
  import vendor_pkg::*;
#(
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int TMO_CYC   = DEF_TMO_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             sense,
  input  logic             clr_fault,
  output logic             drive,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] pend,
  output logic             busy,
  output logic             ovf
);

  localparam int TW = $clog2(max3(PULSE_CYC, TMO_CYC, GAP_CYC)) + 1;
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

  chan_state_t   state;
  logic [TW-1:0] timer;
  logic          start;

  assign start = (state == ST_IDLE) && (pend != '0);

  // NOTE: async reset in the sensitivity list and <= only, so every flop
  // updates from pre-edge values and the reset drops drives immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      unique case ({req, start})
        2'b10: begin
          if (pend == PEND_MAX) ovf <= 1'b1;
          else                  pend <= pend + 1'b1;
        end
        2'b01:   pend <= pend - 1'b1;
        default: pend <= pend;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
      done  <= 1'b0;
    end else begin
      // NOTE: done defaults low every edge so it is a single-cycle pulse.
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_DRIVE;
            timer <= TW'(PULSE_CYC - 1);
          end
        end
        ST_DRIVE: begin
          if (timer == '0) begin
            state <= ST_WAIT;
            timer <= TW'(TMO_CYC - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_WAIT: begin
          if (sense) begin
            state <= ST_GAP;
            timer <= TW'(GAP_CYC - 1);
            done  <= 1'b1;
          end else if (timer == '0) begin
            state <= ST_FAULT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_GAP: begin
          if (timer == '0) state <= ST_IDLE;
          else             timer <= timer - 1'b1;
        end
        ST_FAULT: begin
          if (clr_fault) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decodes of the state register only; no combinational input paths.
  assign drive = (state == ST_DRIVE);
  assign fault = (state == ST_FAULT);
  assign busy  = (state != ST_IDLE) || (pend != '0);

endmodule

// File: rtl/vendor_dispenser.sv
// Output-side dispenser: two independent eject channels (product, coin)
// sharing a fault clear; busy and overflow are merged across channels.
module vendor_dispenser
  import vendor_pkg::*;
#(
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int TMO_CYC   = DEF_TMO_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prod_req,
  input  logic             coin_req,
  input  logic             prod_sense,
  input  logic             coin_sense,
  input  logic             clr_fault,
  output logic             prod_drive,
  output logic             coin_drive,
  output logic             prod_done,
  output logic             coin_done,
  output logic             prod_fault,
  output logic             coin_fault,
  output logic [CNT_W-1:0] prod_pend,
  output logic [CNT_W-1:0] coin_pend,
  output logic             busy,
  output logic             ovf
);

  logic prod_busy, coin_busy;
  logic prod_ovf,  coin_ovf;

  vendor_eject_channel #(
    .PULSE_CYC(PULSE_CYC), .TMO_CYC(TMO_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)
  ) u_prod (
    .clk       (clk),
    .rst       (rst),
    .req       (prod_req),
    .sense     (prod_sense),
    .clr_fault (clr_fault),
    .drive     (prod_drive),
    .done      (prod_done),
    .fault     (prod_fault),
    .pend      (prod_pend),
    .busy      (prod_busy),
    .ovf       (prod_ovf)
  );

  vendor_eject_channel #(
    .PULSE_CYC(PULSE_CYC), .TMO_CYC(TMO_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)
  ) u_coin (
    .clk       (clk),
    .rst       (rst),
    .req       (coin_req),
    .sense     (coin_sense),
    .clr_fault (clr_fault),
    .drive     (coin_drive),
    .done      (coin_done),
    .fault     (coin_fault),
    .pend      (coin_pend),
    .busy      (coin_busy),
    .ovf       (coin_ovf)
  );

  assign busy = prod_busy | coin_busy;
  assign ovf  = prod_ovf  | coin_ovf;

endmodule

// File: tb/tb_vendor_dispenser.sv
// Scoreboard bench for vendor_dispenser: expected drive edges and done
// pulses are queued with their cycle numbers and matched by a monitor.
module tb_vendor_dispenser;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             prod_req = 1'b0, coin_req = 1'b0;
  logic             prod_sense = 1'b0, coin_sense = 1'b0;
  logic             clr_fault = 1'b0;
  logic             prod_drive, coin_drive, prod_done, coin_done;
  logic             prod_fault, coin_fault, busy, ovf;
  logic [CNT_W-1:0] prod_pend, coin_pend;

  vendor_dispenser #(
    .PULSE_CYC(8), .TMO_CYC(16), .GAP_CYC(4), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_req   (prod_req),
    .coin_req   (coin_req),
    .prod_sense (prod_sense),
    .coin_sense (coin_sense),
    .clr_fault  (clr_fault),
    .prod_drive (prod_drive),
    .coin_drive (coin_drive),
    .prod_done  (prod_done),
    .coin_done  (coin_done),
    .prod_fault (prod_fault),
    .coin_fault (coin_fault),
    .prod_pend  (prod_pend),
    .coin_pend  (coin_pend),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Event queue indices: expected cycle numbers per event kind.
  localparam int Q_PR = 0, Q_PF = 1, Q_PD = 2, Q_CR = 3, Q_CF = 4, Q_CD = 5;
  int exp_q [6][$];

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int k, input string tag, input int obs);
    if (exp_q[k].size() == 0) check(tag, obs, -1);
    else                      check(tag, obs, exp_q[k].pop_front());
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic queues_empty(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 6; k++) n += exp_q[k].size();
    check(tag, n, 0);
  endtask

  // Monitor on the falling edge, away from the active edge.
  initial begin
    logic pd_prev, cd_prev;
    pd_prev = 1'b0;
    cd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prod_drive && !pd_prev) expect_evt(Q_PR, "prod_drive_rise", cyc);
      if (!prod_drive && pd_prev) expect_evt(Q_PF, "prod_drive_fall", cyc);
      if (prod_done)              expect_evt(Q_PD, "prod_done", cyc);
      if (coin_drive && !cd_prev) expect_evt(Q_CR, "coin_drive_rise", cyc);
      if (!coin_drive && cd_prev) expect_evt(Q_CF, "coin_drive_fall", cyc);
      if (coin_done)              expect_evt(Q_CD, "coin_done", cyc);
      pd_prev = prod_drive;
      cd_prev = coin_drive;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {prod_drive, coin_drive, prod_done, coin_done,
                          prod_fault, coin_fault, busy, ovf}, 0);
    check("rst_prod_pend", prod_pend, 0);
    check("rst_coin_pend", coin_pend, 0);
    rst = 1'b0;
    goto(cyc + 2);

    // 1: single product job, sensed at cycle 12
    b = cyc;
    exp_q[Q_PR].push_back(b + 2);
    exp_q[Q_PF].push_back(b + 10);
    exp_q[Q_PD].push_back(b + 13);
    prod_req = 1'b1;
    goto(b + 1); prod_req = 1'b0;
    check("t1_pend", prod_pend, 1);
    goto(b + 12); prod_sense = 1'b1;
    goto(b + 13); prod_sense = 1'b0;
    goto(b + 16); check("t1_busy_gap", busy, 1);
    goto(b + 17); check("t1_busy_idle", busy, 0);
    queues_empty("t1_events");

    // 2: simultaneous product and change jobs
    goto(cyc + 2);
    b = cyc;
    exp_q[Q_PR].push_back(b + 2);  exp_q[Q_CR].push_back(b + 2);
    exp_q[Q_PF].push_back(b + 10); exp_q[Q_CF].push_back(b + 10);
    exp_q[Q_PD].push_back(b + 12); exp_q[Q_CD].push_back(b + 12);
    prod_req = 1'b1; coin_req = 1'b1;
    goto(b + 1); prod_req = 1'b0; coin_req = 1'b0;
    check("t2_pend_both", {prod_pend, coin_pend}, {3'd1, 3'd1});
    goto(b + 11); prod_sense = 1'b1; coin_sense = 1'b1;
    goto(b + 12); prod_sense = 1'b0; coin_sense = 1'b0;
    goto(b + 16); check("t2_busy_idle", busy, 0);
    queues_empty("t2_events");

    // 3: three back-to-back change jobs, sensed on the first wait cycle
    goto(cyc + 2);
    b = cyc;
    for (int j = 0; j < 3; j++) begin
      exp_q[Q_CR].push_back(b + 2 + 14 * j);
      exp_q[Q_CF].push_back(b + 10 + 14 * j);
      exp_q[Q_CD].push_back(b + 11 + 14 * j);
    end
    coin_req = 1'b1;
    goto(b + 3); coin_req = 1'b0;
    check("t3_pend_peak", coin_pend, 2);
    for (int j = 0; j < 3; j++) begin
      goto(b + 10 + 14 * j); coin_sense = 1'b1;
      goto(b + 11 + 14 * j); coin_sense = 1'b0;
    end
    goto(b + 42); check("t3_busy_gap", busy, 1);
    goto(b + 43); check("t3_busy_idle", busy, 0);
    queues_empty("t3_events");

    // 4: product timeout, queued job held, then resumed by clr_fault
    goto(cyc + 2);
    b = cyc;
    exp_q[Q_PR].push_back(b + 2);
    exp_q[Q_PF].push_back(b + 10);
    prod_req = 1'b1;
    goto(b + 1); prod_req = 1'b0;
    goto(b + 25); check("t4_fault_pre", prod_fault, 0);
    goto(b + 26); check("t4_fault", prod_fault, 1);
    goto(b + 27); prod_req = 1'b1;
    goto(b + 28); prod_req = 1'b0;
    check("t4_pend_held", prod_pend, 1);
    goto(b + 30); check("t4_no_drive", prod_drive, 0);
    exp_q[Q_PR].push_back(b + 33);
    exp_q[Q_PF].push_back(b + 41);
    exp_q[Q_PD].push_back(b + 42);
    goto(b + 31); clr_fault = 1'b1;
    goto(b + 32); clr_fault = 1'b0;
    check("t4_fault_clr", prod_fault, 0);
    check("t4_pend_kept", prod_pend, 1);
    goto(b + 41); prod_sense = 1'b1;
    goto(b + 42); prod_sense = 1'b0;
    goto(b + 46); check("t4_busy_idle", busy, 0);
    queues_empty("t4_events");

    // 5: change counter saturation while the coin channel is faulted
    goto(cyc + 2);
    b = cyc;
    exp_q[Q_CR].push_back(b + 2);
    exp_q[Q_CF].push_back(b + 10);
    coin_req = 1'b1;
    goto(b + 1); coin_req = 1'b0;
    goto(b + 26); check("t5_fault", coin_fault, 1);
    goto(b + 27); coin_req = 1'b1;
    goto(b + 34); check("t5_pend_7", coin_pend, 7);
    check("t5_ovf_pre", ovf, 0);
    goto(b + 35); coin_req = 1'b0;
    check("t5_pend_sat", coin_pend, 7);
    check("t5_ovf", ovf, 1);
    exp_q[Q_CR].push_back(b + 38);
    exp_q[Q_CF].push_back(b + 46);
    goto(b + 36); clr_fault = 1'b1;
    goto(b + 37); clr_fault = 1'b0;
    check("t5_fault_clr", coin_fault, 0);
    check("t5_ovf_sticky", ovf, 1);
    goto(b + 62);
    check("t5_refault", coin_fault, 1);
    check("t5_pend_6", coin_pend, 6);
    queues_empty("t5_events");

    // 6: reset in the middle of a product drive with two jobs queued
    goto(cyc + 2);
    b = cyc;
    exp_q[Q_PR].push_back(b + 2);
    exp_q[Q_PF].push_back(b + 5);
    prod_req = 1'b1;
    goto(b + 3); prod_req = 1'b0;
    check("t6_pend", prod_pend, 2);
    goto(b + 5);
    rst = 1'b1;
    #1;
    check("t6_drive_async", prod_drive, 0);
    check("t6_pend_clr", {prod_pend, coin_pend}, 0);
    check("t6_flags_clr", {coin_fault, ovf, busy}, 0);
    goto(b + 7); rst = 1'b0;
    // Spurious sensor pulses and a stray clear while idle
    goto(b + 9);  prod_sense = 1'b1;
    goto(b + 10); prod_sense = 1'b0; coin_sense = 1'b1;
    goto(b + 11); coin_sense = 1'b0; clr_fault = 1'b1;
    goto(b + 12); clr_fault = 1'b0;
    goto(b + 20);
    check("t6_idle", {prod_drive, coin_drive, prod_fault, coin_fault, busy, ovf}, 0);
    queues_empty("t6_events");

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vendor_dispenser.md
Name: vendor_dispenser

Overview:
Output-side companion to the coin-accepting vending FSM. Consumes its single-cycle "dispense product" (outz) and "return 5-unit change" (outo) pulses and queues them. Drives the product motor and coin ejector actuators with timed pulses and confirms each with a drop sensor. Reports completion, timeout faults and queue overflow to the panel logic.

Parameters:
PULSE_CYC, 8, cycles each actuator drive is held high (>=1)
TMO_CYC, 16, max cycles to wait for the drop sensor after the drive ends (>=1)
GAP_CYC, 4, cooldown cycles after a confirmed drop before the next job (>=1)
CNT_W, 3, width of each channel's pending-job counter (max 2^CNT_W-1 queued)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
prod_req  in  1  one-cycle product request (from outz)
coin_req  in  1  one-cycle change request (from outo)
prod_sense  in  1  product drop sensor, synchronous, high = item passed
coin_sense  in  1  coin drop sensor, synchronous, high = coin passed
clr_fault  in  1  one-cycle fault clear, both channels
prod_drive  out  1  product motor enable
coin_drive  out  1  coin ejector enable
prod_done  out  1  one-cycle pulse per confirmed product drop
coin_done  out  1  one-cycle pulse per confirmed coin drop
prod_fault  out  1  sticky product-channel timeout fault
coin_fault  out  1  sticky coin-channel timeout fault
prod_pend  out  CNT_W  queued product jobs not yet started
coin_pend  out  CNT_W  queued change jobs not yet started
busy  out  1  either channel not IDLE or either pend non-zero
ovf  out  1  sticky: a request arrived on a saturated counter

Behaviour:
- Reset: all outputs 0, both channels IDLE, counters 0, ovf 0. Reset mid-job drops drives in the same cycle (async) and discards all queued jobs.
- Two independent identical channels; no ordering between product and coin. Simultaneous requests on both are each accepted.
- Pending counter per channel, updated each edge:
  - req only: +1.
  - job start only: -1.
  - req and start in the same cycle: unchanged.
  - req while counter = 2^CNT_W-1 and no start: counter holds, ovf set.
  - ovf clears only on rst.
- Channel FSM states: IDLE, DRIVE, WAIT, GAP, FAULT.
  - IDLE: if pend != 0 -> DRIVE on the next edge, pend decrements on that edge. A req at cycle 0 gives pend=1 after edge 1 and drive=1 after edge 2 (2-cycle latency).
  - DRIVE: drive=1 for exactly PULSE_CYC cycles, then -> WAIT. Sensor ignored in DRIVE.
  - WAIT: drive=0; sense sampled each cycle.
    - sense=1 within TMO_CYC cycles -> GAP; done=1 for the single cycle on GAP entry.
    - TMO_CYC cycles elapse without sense -> FAULT.
  - GAP: GAP_CYC cycles, then -> IDLE. Sense ignored.
  - FAULT: fault=1, drive=0; requests still counted, no jobs started; clr_fault -> IDLE (fault=0 next cycle), pending jobs retained and resume normally.
- clr_fault outside FAULT: no effect.
- Sense in IDLE (spurious drop): ignored, no done.
- All outputs registered; drive is a direct state decode from a register.
- Timer: one down-counter per channel, width clog2(max(PULSE_CYC,TMO_CYC,GAP_CYC))+1, reloaded on each state entry.

Decomposition:
- Package vendor_pkg: channel state encoding (IDLE/DRIVE/WAIT/GAP/FAULT) and the default timing constants. Shared with the vending FSM package for the coin/product encodings.
- Sub-module vendor_eject_channel: one counter + FSM + timer, parameterised by PULSE_CYC/TMO_CYC/GAP_CYC/CNT_W. Instantiated twice (product, coin).
- The top only ORs busy, and ORs the per-channel overflow flags into ovf.

Test Plan:
- Single prod_req at cycle 0; prod_sense=1 at cycle 12 -> prod_drive high cycles 2-9, prod_done pulse at cycle 13, busy low from cycle 17.
- prod_req and coin_req both at cycle 0; sense both at cycle 11 -> both drives high cycles 2-9 concurrently, both done pulses at cycle 12.
- 3 coin_req on consecutive cycles; sense 1 cycle after each drive ends -> coin_pend peaks 2, three drive pulses of 8 cycles each separated by 4-cycle gaps plus the 1-cycle wait, three coin_done pulses.
- prod_req, no sense -> prod_fault=1 after 8 drive + 16 wait cycles. A further prod_req gives prod_pend=1 with no drive. clr_fault -> next cycle fault=0, and the queued job drives 1 cycle later.
- 8 coin_req while a fault blocks the channel (CNT_W=3) -> coin_pend saturates at 7, ovf=1 and stays 1 after clr_fault.
- rst asserted during DRIVE with pend=2 -> drive=0 immediately, pend=0, state IDLE, no done.
